awb_gain_ctrl: RTL and testbench
================================

Name: awb_gain_ctrl

Overview:
- Gray-world auto-white-balance controller that sets the per-channel gains used by the white-balance stage.
- Taps the same pixel stream (valid/color/value/last) that enters white balance and accumulates per-channel sums over one frame.
- At end of frame, computes K_R, K_G, K_B in Q8.8 (unity = 16'h0100) using a shared sequential divider, then updates all three gains atomically.
- Gain outputs connect directly to the white-balance gain inputs and its valid_gain qualifier.

Parameters:
- ACC_W, 32: width of each per-channel sum accumulator.
- G_SHIFT, 1: right shift applied to the green sum to normalise for Bayer green density. Use 1 for RGGB, 0 for equal densities.
- GAIN_MIN, 16'h0010: lower clamp for computed gains.
- GAIN_MAX, 16'h0FF0: upper clamp for computed gains. This is the largest value representable in gain bits [11:4].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  1 = automatic gain computation; 0 = gains frozen and accumulation stalled
- manual_i  in  1  1 = gain outputs follow man_k*_i, bypassing computation
- man_kr_i / man_kg_i / man_kb_i  in  16 each  manual gains, Q8.8
- valid_i  in  1  pixel qualifier
- color_i  in  2  0 = R, 1 = G, 2 = B, 3 = ignored
- value_i  in  8  pixel value
- last_i  in  1  last pixel of frame; qualified by valid_i
- K_R / K_G / K_B  out  16 each  applied gains, Q8.8
- valid_gain_o  out  1  gains usable
- update_o  out  1  one-cycle pulse when gains change from a computation
- busy_o  out  1  high in the DIV_R, DIV_B and UPDATE states
- drop_o  out  1  one-cycle pulse when a frame's statistics are discarded

Behaviour:
- Reset:
  - K_R, K_G, K_B = 16'h0100.
  - valid_gain_o, update_o, busy_o, drop_o = 0.
  - Accumulators and snapshots cleared; FSM in IDLE.
  - valid_gain_o rises at the first clk edge after reset release and stays 1 until the next reset.
- Accumulation (independent of FSM state, only while enable_i = 1):
  - On valid_i, add value_i to sum_r, sum_g or sum_b according to color_i; color 3 is ignored.
  - Each sum saturates at all-ones.
  - A pixel with last_i is included in the sum, then all three sums are cleared in the same cycle.
- FSM states: IDLE, DIV_R, DIV_B, UPDATE.
- IDLE:
  - On valid_i & last_i & enable_i, snapshot the three sums (including the last pixel) into operand registers, then go to DIV_R.
- DIV_R:
  - Dividend = (sum_g >> G_SHIFT) << 8; divisor = sum_r.
  - Restoring divider, 1 quotient bit per cycle, ACC_W + 8 cycles.
  - Then go to DIV_B.
- DIV_B:
  - Same computation with divisor = sum_b.
  - Then go to UPDATE.
- UPDATE (1 cycle):
  - K_R = clamp(q_r); K_B = clamp(q_b); K_G = 16'h0100. All three are registered in the same edge.
  - update_o = 1; then return to IDLE.
  - Unless manual_i = 1, in which case the computed values are discarded and update_o = 0.
- Clamp and divide-by-zero rules:
  - clamp(q) = GAIN_MAX if q > GAIN_MAX; GAIN_MIN if q < GAIN_MIN; otherwise q[15:0].
  - Divisor = 0 gives GAIN_MAX, without running the divide.
  - Total end-of-frame latency from last_i to K update = 2·(ACC_W + 8) + 2 cycles (82 at default).
- Frame overlap:
  - last_i arriving while not in IDLE: that frame's statistics are discarded, accumulators still clear, drop_o pulses.
  - The computation in progress is unaffected.
- manual_i = 1: K_* equal man_k*_i registered, with 1-cycle latency, every cycle. Accumulation and computation continue in the background.
- enable_i = 0:
  - Accumulators hold.
  - An in-progress computation completes and updates normally.
  - No new computation starts.
- Mid-operation reset: behaves as a full reset; no partial update is visible.

Optional Feature:
- AWB_IIR_EN defined:
  - UPDATE applies temporal smoothing: K_new = K_old + ((clamp(q) − K_old) >>> 2), using signed 17-bit arithmetic.
  - The result is re-clamped to [GAIN_MIN, GAIN_MAX].
- Undefined: UPDATE loads clamp(q) directly.

Decomposition:
- Shared package isp_pkg holds:
  - color codes (COLOR_R = 0, COLOR_G = 1, COLOR_B = 2);
  - GAIN_UNITY = 16'h0100;
  - the FSM state enum.
- One sub-module: seq_div, a restoring unsigned divider.
  - Parameter: width.
  - Interface: start / dividend / divisor in; done / quotient out.
  - Instantiated once and time-shared between the R and B divisions.

Test Plan:
- Reset, no pixels -> K_* = 0x0100, valid_gain_o = 1 after the first edge, update_o never pulses.
- 64 RGGB quads with R=50, G=100, B=200, last on the final pixel -> after 82 cycles: K_R = 0x0200, K_G = 0x0100, K_B = 0x0080, update_o pulses once.
- Frame with all R = 0, G = 100, B = 100 -> K_R = 0x0FF0 (divide-by-zero), K_B = 0x0100.
- Second last_i arriving 10 cycles after the first -> drop_o pulses, gains come from the first frame only, next frame accumulates from zero.
- manual_i = 1 with man_kr_i = 0x0180 during a computation -> K_R = 0x0180 one cycle later, computed result discarded, update_o = 0.
- With AWB_IIR_EN defined: K_R old = 0x0100, computed 0x0200 -> K_R = 0x0140 after UPDATE.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer color codes, unity gain, and the AWB controller state encoding.
package isp_pkg;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  localparam logic [15:0] GAIN_UNITY = 16'h0100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV_R  = 2'd1,
    ST_DIV_B  = 2'd2,
    ST_UPDATE = 2'd3
  } awb_state_t;

endpackage

// File: rtl/awb_gain_ctrl_if.sv
// Pixel statistics tap: the same valid/color/value/last stream that feeds the white-balance stage.
interface awb_gain_ctrl_if;
  logic       valid_i;
  logic [1:0] color_i;
  logic [7:0] value_i;
  logic       last_i;

  modport master (output valid_i, color_i, value_i, last_i);
  modport slave  (input  valid_i, color_i, value_i, last_i);
endinterface

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per clock; the start cycle already retires the first bit.
module seq_div #(
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CW-1:0]      cnt_q;
  logic               running_q;
  logic [2*WIDTH-1:0] step_res;

  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] q_n;
    trial = {rem, quo[WIDTH-1]};
    q_n   = {quo[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, dvs}) begin
      r_n    = WIDTH'(trial - {1'b0, dvs});
      q_n[0] = 1'b1;
    end else begin
      r_n = WIDTH'(trial);
    end
    return {r_n, q_n};
  endfunction

  always_comb begin
    step_res = '0;
    if (start) step_res = div_step('0, dividend, divisor);
    else       step_res = div_step(rem_q, quotient, divisor_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quotient  <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      {rem_q, quotient} <= step_res;
      divisor_q         <= divisor;
      cnt_q             <= CW'(WIDTH - 1);
      running_q         <= 1'b1;
      done              <= 1'b0;
    end else if (running_q) begin
      {rem_q, quotient} <= step_res;
      cnt_q             <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        running_q <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Gray-world AWB gain controller: per-frame channel sums -> K_R/K_B = (G>>G_SHIFT)/R|B in Q8.8.
// Build option AWB_IIR_EN: UPDATE blends the new gain into the old one (quarter-step IIR).
module awb_gain_ctrl
  import isp_pkg::*;
#(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned G_SHIFT  = 1,
  parameter logic [15:0] GAIN_MIN = 16'h0010,
  parameter logic [15:0] GAIN_MAX = 16'h0FF0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  manual_i,
  input  logic [15:0]           man_kr_i,
  input  logic [15:0]           man_kg_i,
  input  logic [15:0]           man_kb_i,
  awb_gain_ctrl_if.slave        pix,
  output logic [15:0]           K_R,
  output logic [15:0]           K_G,
  output logic [15:0]           K_B,
  output logic                  valid_gain_o,
  output logic                  update_o,
  output logic                  busy_o,
  output logic                  drop_o
);

  localparam int unsigned DIV_W = ACC_W + 8;
  localparam int unsigned CW    = $clog2(DIV_W + 1);

  awb_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [ACC_W-1:0] sum_r_q, sum_g_q, sum_b_q;
  logic [ACC_W-1:0] sum_r_nx, sum_g_nx, sum_b_nx;
  logic [ACC_W-1:0] snap_r_q, snap_b_q;
  logic [DIV_W-1:0] g_div_q, g_div_nx;
  logic [15:0]      gain_r_q, gain_b_q;
  logic             pix_last, frame_start;
  logic             div_start, div_done;
  logic [DIV_W-1:0] div_dividend, div_divisor, div_quotient;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] s, input logic [7:0] v);
    logic [ACC_W:0] t;
    t = {1'b0, s} + (ACC_W + 1)'(v);
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  function automatic logic [15:0] clamp_q(input logic [DIV_W-1:0] q);
    if (q > DIV_W'(GAIN_MAX))      return GAIN_MAX;
    else if (q < DIV_W'(GAIN_MIN)) return GAIN_MIN;
    else                           return 16'(q);
  endfunction

`ifdef AWB_IIR_EN
  function automatic logic [15:0] smooth(input logic [15:0] old_k, input logic [15:0] new_k);
    logic signed [16:0] diff;
    logic signed [16:0] acc;
    diff = $signed({1'b0, new_k}) - $signed({1'b0, old_k});
    acc  = $signed({1'b0, old_k}) + (diff >>> 2);
    if (acc > $signed({1'b0, GAIN_MAX}))      return GAIN_MAX;
    else if (acc < $signed({1'b0, GAIN_MIN})) return GAIN_MIN;
    else                                      return 16'(acc);
  endfunction
`endif

  assign pix_last    = pix.valid_i & pix.last_i & enable_i;
  assign frame_start = pix_last && (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);

  // Next-sum values include the current pixel so the last pixel lands in the snapshot.
  always_comb begin
    sum_r_nx = sum_r_q;
    sum_g_nx = sum_g_q;
    sum_b_nx = sum_b_q;
    if (pix.valid_i) begin
      if (pix.color_i == COLOR_R) sum_r_nx = sat_add(sum_r_q, pix.value_i);
      if (pix.color_i == COLOR_G) sum_g_nx = sat_add(sum_g_q, pix.value_i);
      if (pix.color_i == COLOR_B) sum_b_nx = sat_add(sum_b_q, pix.value_i);
    end
    g_div_nx = {ACC_W'(sum_g_nx >> G_SHIFT), 8'h00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
    end else if (enable_i) begin
      if (pix_last) begin
        sum_r_q <= '0;
        sum_g_q <= '0;
        sum_b_q <= '0;
      end else begin
        sum_r_q <= sum_r_nx;
        sum_g_q <= sum_g_nx;
        sum_b_q <= sum_b_nx;
      end
    end
  end

  // The R divide launches straight from the live sums on the frame-start edge; B launches when R retires.
  always_comb begin
    div_start    = 1'b0;
    div_dividend = g_div_q;
    div_divisor  = {8'h00, snap_b_q};
    if (frame_start) begin
      div_start    = (sum_r_nx != '0);
      div_dividend = g_div_nx;
      div_divisor  = {8'h00, sum_r_nx};
    end else if (state_q == ST_DIV_R && cnt_q == '0) begin
      div_start = (snap_b_q != '0);
    end
  end

  seq_div #(.WIDTH(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      snap_r_q     <= '0;
      snap_b_q     <= '0;
      g_div_q      <= '0;
      gain_r_q     <= GAIN_UNITY;
      gain_b_q     <= GAIN_UNITY;
      K_R          <= GAIN_UNITY;
      K_G          <= GAIN_UNITY;
      K_B          <= GAIN_UNITY;
      valid_gain_o <= 1'b0;
      update_o     <= 1'b0;
      drop_o       <= 1'b0;
    end else begin
      valid_gain_o <= 1'b1;
      update_o     <= 1'b0;
      drop_o       <= pix_last && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            snap_r_q <= sum_r_nx;
            snap_b_q <= sum_b_nx;
            g_div_q  <= g_div_nx;
            cnt_q    <= CW'(DIV_W - 1);
            state_q  <= ST_DIV_R;
          end
        end
        ST_DIV_R: begin
          if (cnt_q == '0) begin
            gain_r_q <= (snap_r_q == '0 || !div_done) ? GAIN_MAX : clamp_q(div_quotient);
            cnt_q    <= CW'(DIV_W - 1);
            state_q  <= ST_DIV_B;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DIV_B: begin
          if (cnt_q == '0) begin
            gain_b_q <= (snap_b_q == '0 || !div_done) ? GAIN_MAX : clamp_q(div_quotient);
            state_q  <= ST_UPDATE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_UPDATE: begin
          state_q <= ST_IDLE;
          if (!manual_i) begin
`ifdef AWB_IIR_EN
            K_R <= smooth(K_R, gain_r_q);
            K_B <= smooth(K_B, gain_b_q);
`else
            K_R <= gain_r_q;
            K_B <= gain_b_q;
`endif
            K_G      <= GAIN_UNITY;
            update_o <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (manual_i) begin
        K_R <= man_kr_i;
        K_G <= man_kg_i;
        K_B <= man_kb_i;
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Scoreboard bench for awb_gain_ctrl: directed frames push expected gains, a negedge monitor checks them.
module tb_awb_gain_ctrl;
  import isp_pkg::*;

  localparam bit IIR     = `ifdef AWB_IIR_EN 1'b1 `else 1'b0 `endif;
  localparam int LATENCY = 82;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i, manual_i;
  logic [15:0] man_kr_i, man_kg_i, man_kb_i;
  logic [15:0] K_R, K_G, K_B;
  logic        valid_gain_o, update_o, busy_o, drop_o;

  always #5 clk = ~clk;

  awb_gain_ctrl_if pix ();

  awb_gain_ctrl #(
    .ACC_W    (32),
    .G_SHIFT  (1),
    .GAIN_MIN (16'h0010),
    .GAIN_MAX (16'h0FF0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .manual_i     (manual_i),
    .man_kr_i     (man_kr_i),
    .man_kg_i     (man_kg_i),
    .man_kb_i     (man_kb_i),
    .pix          (pix),
    .K_R          (K_R),
    .K_G          (K_G),
    .K_B          (K_B),
    .valid_gain_o (valid_gain_o),
    .update_o     (update_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o)
  );

  typedef struct {
    int          cyc;
    logic [15:0] kr, kg, kb;
    logic        vg, busy;
    int          id;
  } chk_t;

  typedef struct {
    int          last_cyc;
    logic [15:0] kr, kg, kb;
  } upd_t;

  chk_t        chk_q[$];
  upd_t        upd_q[$];
  int          drop_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          chk_id = 0;
  bit          stop = 1'b0;
  logic [15:0] cur_kr = 16'h0100;
  logic [15:0] cur_kb = 16'h0100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] next_gain(input logic [15:0] old_k, input logic [15:0] q);
    int d, n;
    d = int'(q) - int'(old_k);
    n = int'(old_k) + (d >>> 2);
    if (n > 'h0FF0) n = 'h0FF0;
    if (n < 'h0010) n = 'h0010;
    return IIR ? 16'(n) : q;
  endfunction

  task automatic add_chk(input int c, input logic [15:0] kr, kg, kb, input logic vg, busy);
    chk_t e;
    e.cyc = c; e.kr = kr; e.kg = kg; e.kb = kb; e.vg = vg; e.busy = busy; e.id = chk_id;
    chk_id++;
    chk_q.push_back(e);
  endtask

  task automatic expect_upd(input int lc, input logic [15:0] qr, input logic [15:0] qb);
    upd_t u;
    cur_kr = next_gain(cur_kr, qr);
    cur_kb = next_gain(cur_kb, qb);
    u.last_cyc = lc; u.kr = cur_kr; u.kg = GAIN_UNITY; u.kb = cur_kb;
    upd_q.push_back(u);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] v, input logic l);
    pix.valid_i = 1'b1; pix.color_i = c; pix.value_i = v; pix.last_i = l;
    @(posedge clk); #1;
    pix.valid_i = 1'b0; pix.last_i = 1'b0;
  endtask

  task automatic frame(input int nq, input logic [7:0] r, g, b, output int lc);
    for (int q = 0; q < nq; q++) begin
      send(COLOR_R, r, 1'b0);
      send(COLOR_G, g, 1'b0);
      send(COLOR_G, g, 1'b0);
      send(COLOR_B, b, q == nq - 1);
    end
    lc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 400);
    if (busy_o) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy_o still 1 after %0d cycles, required 0", n);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: timed state checks, update scoreboard, drop scoreboard.
  initial begin
    chk_t c;
    upd_t u;
    bit   prev_upd = 1'b0;
    while (!stop) begin
      @(negedge clk);
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
        c = chk_q.pop_front();
        cmp($sformatf("chk%0d K_R", c.id), K_R, c.kr);
        cmp($sformatf("chk%0d K_G", c.id), K_G, c.kg);
        cmp($sformatf("chk%0d K_B", c.id), K_B, c.kb);
        cmp($sformatf("chk%0d valid_gain", c.id), 16'(valid_gain_o), 16'(c.vg));
        cmp($sformatf("chk%0d busy", c.id), 16'(busy_o), 16'(c.busy));
      end
      if (update_o) begin
        cmp("update_pulse_width", 16'(prev_upd), 16'h0);
        if (upd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_update: update_o 1 at cycle %0d, required 0", cyc);
        end else begin
          u = upd_q.pop_front();
          cmp("upd K_R", K_R, u.kr);
          cmp("upd K_G", K_G, u.kg);
          cmp("upd K_B", K_B, u.kb);
          cmp("upd latency", 16'(cyc - u.last_cyc + 1), 16'(LATENCY));
        end
      end
      prev_upd = update_o;
      if (drop_o) begin
        vectors++;
        if (drop_q.size() == 0 || drop_q[0] != cyc) begin
          miscompares++;
          $display("FAIL drop_pulse: drop_o 1 at cycle %0d, expected at %0d", cyc,
                   (drop_q.size() == 0) ? -1 : drop_q[0]);
        end else begin
          void'(drop_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lc;
    enable_i = 1'b1; manual_i = 1'b0;
    man_kr_i = '0; man_kg_i = '0; man_kb_i = '0;
    pix.valid_i = 1'b0; pix.color_i = '0; pix.value_i = '0; pix.last_i = 1'b0;

    add_chk(2, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0);
    add_chk(4, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0);
    add_chk(30, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // 64 RGGB quads: R=3200, G=12800 (>>1 = 6400), B=12800
    frame(64, 8'd50, 8'd100, 8'd200, lc);
    expect_upd(lc, 16'h0200, 16'h0080);
    wait_idle();

    // R sum zero -> divide-by-zero gain
    frame(16, 8'd0, 8'd100, 8'd100, lc);
    expect_upd(lc, 16'h0FF0, 16'h0100);
    wait_idle();

    // Second last_i 10 cycles after the first is dropped
    frame(16, 8'd50, 8'd100, 8'd200, lc);
    expect_upd(lc, 16'h0200, 16'h0080);
    for (int i = 0; i < 9; i++) send(2'(i % 4), 8'd200, 1'b0);
    send(COLOR_B, 8'd200, 1'b1);
    drop_q.push_back(cyc);
    wait_idle();

    // Accumulation and start frozen while disabled
    enable_i = 1'b0;
    frame(4, 8'd255, 8'd1, 8'd1, lc);
    repeat (5) @(posedge clk);
    #1;
    add_chk(cyc + 1, cur_kr, GAIN_UNITY, cur_kb, 1'b1, 1'b0);
    enable_i = 1'b1;

    // Equal channels from a cleared accumulator -> unity
    frame(16, 8'd100, 8'd100, 8'd100, lc);
    expect_upd(lc, 16'h0100, 16'h0100);
    wait_idle();

    // Manual override mid-computation discards the computed result
    frame(16, 8'd50, 8'd100, 8'd200, lc);
    repeat (20) @(posedge clk);
    #1;
    manual_i = 1'b1;
    man_kr_i = 16'h0180; man_kg_i = 16'h0120; man_kb_i = 16'h00C0;
    add_chk(cyc + 1, 16'h0180, 16'h0120, 16'h00C0, 1'b1, 1'b1);
    cur_kr = 16'h0180;
    cur_kb = 16'h00C0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    add_chk(cyc + 1, 16'h0180, 16'h0120, 16'h00C0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    manual_i = 1'b0;
    man_kr_i = '0; man_kg_i = '0; man_kb_i = '0;
    add_chk(cyc + 2, 16'h0180, 16'h0120, 16'h00C0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Automatic updates resume after manual release
    frame(16, 8'd50, 8'd100, 8'd200, lc);
    expect_upd(lc, 16'h0200, 16'h0080);
    wait_idle();

    repeat (10) @(posedge clk);
    stop = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (upd_q.size() != 0 || chk_q.size() != 0 || drop_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations: got upd=%0d chk=%0d drop=%0d left, expected 0",
               upd_q.size(), chk_q.size(), drop_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
